// File: rtl/frame_tx_scheduler_pkg.sv
// Shared definitions for the frame transmit scheduler: default geometry,
// timing constants, FSM state encoding and a counter reload helper.
package frame_tx_scheduler_pkg;

  localparam int DEF_ADDR_W          = 20;
  localparam int DEF_FRAME_LAST_ADDR = 57599;   // 320*180-1
  localparam int DEF_NUM_CLONES      = 2;
  localparam int DEF_IFG_CYCLES      = 32;
  localparam int DEF_ACK_TIMEOUT     = 4095;

  // Width of the shared gap/ack down-counter.
  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  // Reload value so that a down-counter reaching zero marks the end of a
  // window of 'cycles' clock cycles (cycles is expected to be >= 1).
  function automatic logic [CNT_W-1:0] cnt_reload(input int cycles);
    if (cycles > 0) begin
      return CNT_W'(cycles - 1);
    end else begin
      return {CNT_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/frame_tx_scheduler_if.sv
// Handshake between the scheduler (master) and the UDP frame generator
// (slave): start pulse plus packet descriptor out, busy/lastaddr back.
interface frame_tx_scheduler_if
  import frame_tx_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              tx_start;
  logic [ADDR_W-1:0] tx_startaddr;
  logic [7:0]        tx_index_clone;
  logic [15:0]       tx_segment_num;
  logic [7:0]        tx_aux;
  logic              tx_busy;
  logic [ADDR_W-1:0] tx_lastaddr;

  modport master (
    output tx_start, tx_startaddr, tx_index_clone, tx_segment_num, tx_aux,
    input  tx_busy, tx_lastaddr
  );

  modport slave (
    input  tx_start, tx_startaddr, tx_index_clone, tx_segment_num, tx_aux,
    output tx_busy, tx_lastaddr
  );

endinterface

// File: rtl/frame_tx_scheduler.sv
// Frame transmit scheduler: walks one VRAM frame in generator-sized
// segments, sending NUM_CLONES copies of each segment, with an ack timeout
// on the start handshake and an inter-frame gap after every packet.
module frame_tx_scheduler
  import frame_tx_scheduler_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int FRAME_LAST_ADDR = DEF_FRAME_LAST_ADDR,
  parameter int NUM_CLONES      = DEF_NUM_CLONES,
  parameter int IFG_CYCLES      = DEF_IFG_CYCLES,
  parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 frame_start,
  frame_tx_scheduler_if.master tx,
  output logic                 frame_busy,
  output logic                 frame_done
);

  // WAIT_ACK lasts ACK_TIMEOUT cycles, so together with the ISSUE cycle a
  // silent generator sees a start pulse every ACK_TIMEOUT+1 cycles.
  localparam logic [CNT_W-1:0]  ACK_LOAD   = cnt_reload(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = cnt_reload(IFG_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [7:0]        LAST_CLONE = 8'(NUM_CLONES - 1);
  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(FRAME_LAST_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] startaddr_q, startaddr_d;
  logic [ADDR_W-1:0] lastaddr_q, lastaddr_d;
  logic [7:0]        clone_q, clone_d;
  logic [15:0]       seg_q, seg_d;
  logic [7:0]        aux_q, aux_d;
  logic              tx_start_q, tx_start_d;
  logic              frame_busy_q, frame_busy_d;
  logic              frame_done_q, frame_done_d;
  logic              pending_q, pending_d;
  logic              frame_finished_s;

  // Next-state and next-output logic for the segment/clone sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    startaddr_d  = startaddr_q;
    lastaddr_d   = lastaddr_q;
    clone_d      = clone_q;
    seg_d        = seg_q;
    aux_d        = aux_q;
    tx_start_d   = 1'b0;
    frame_busy_d = frame_busy_q;
    frame_done_d = 1'b0;
    // A trigger arriving while a frame is in flight is remembered once.
    pending_d    = pending_q | (frame_start & frame_busy_q);
    // Frame is exhausted at the end address, or when the generator wrapped
    // its address back to zero part way through the frame.
    frame_finished_s = (lastaddr_q >= FRAME_LAST) ||
                       ((lastaddr_q == ADDR_ZERO) && (startaddr_q != ADDR_ZERO));

    case (state_q)
      ST_IDLE: begin
        if ((frame_start | pending_q) & enable) begin
          startaddr_d  = ADDR_ZERO;
          clone_d      = 8'd0;
          seg_d        = 16'd0;
          frame_busy_d = 1'b1;
          pending_d    = 1'b0;
          state_d      = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        tx_start_d = 1'b1;
        cnt_d      = ACK_LOAD;
        state_d    = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (tx.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Entered with busy high, so the first low sample is the falling edge.
      ST_WAIT_DONE: begin
        if (!tx.tx_busy) begin
          lastaddr_d = tx.tx_lastaddr;
          cnt_d      = GAP_LOAD;
          state_d    = ST_GAP;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_GAP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!enable) begin
          frame_busy_d = 1'b0;
          state_d      = ST_IDLE;
        end else if (clone_q < LAST_CLONE) begin
          clone_d = clone_q + 8'd1;
          state_d = ST_ISSUE;
        end else if (frame_finished_s) begin
          clone_d      = 8'd0;
          frame_done_d = 1'b1;
          frame_busy_d = 1'b0;
          aux_d        = aux_q + 8'd1;
          state_d      = ST_IDLE;
        end else begin
          clone_d     = 8'd0;
          startaddr_d = lastaddr_q + ADDR_W'(1);
          seg_d       = seg_q + 16'd1;
          state_d     = ST_ISSUE;
        end
      end

      default: begin
        frame_busy_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      startaddr_q  <= ADDR_ZERO;
      lastaddr_q   <= ADDR_ZERO;
      clone_q      <= 8'd0;
      seg_q        <= 16'd0;
      aux_q        <= 8'd0;
      tx_start_q   <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      startaddr_q  <= startaddr_d;
      lastaddr_q   <= lastaddr_d;
      clone_q      <= clone_d;
      seg_q        <= seg_d;
      aux_q        <= aux_d;
      tx_start_q   <= tx_start_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
    end
  end

  assign tx.tx_start       = tx_start_q;
  assign tx.tx_startaddr   = startaddr_q;
  assign tx.tx_index_clone = clone_q;
  assign tx.tx_segment_num = seg_q;
  assign tx.tx_aux         = aux_q;
  assign frame_busy        = frame_busy_q;
  assign frame_done        = frame_done_q;

endmodule
